multdiv_ctrl: RTL and testbench

- Sequencing controller between the pipeline's execute stage and the shared multi-cycle multiply/divide unit.
- Accepts one mult or div request, latches operands and destination tag, and issues a single-cycle start pulse (ctrl_MULT or ctrl_DIV).
- Waits for the unit's ready, then presents a tagged result with valid/ready backpressure.
- Short-circuits divide-by-zero, enforces a watchdog timeout and supports pipeline flush.

---
 rtl/multdiv_ctrl_if.sv | 57 +++++
 rtl/multdiv_ctrl.sv | 142 ++++++++++++++
 tb/tb_multdiv_ctrl.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl_if
//
// Bundles every handshake and data signal between the multiply/divide
// controller and its neighbours: the execute stage (request side), the
// writeback consumer (response side) and the shared multi-cycle
// multiply/divide unit.
//
// Modports:
//   slave  - the controller's view (multdiv_ctrl).
//   master - the environment's view: execute stage, consumer and unit.
//
// Signal summary:
//   req_valid/req_ready/req_op/req_a/req_b/req_rd  request handshake + payload
//   flush                                          abort in-flight operation
//   busy                                           pipeline stall
//   unit_a/unit_b/ctrl_MULT/ctrl_DIV               operands + start pulses
//   unit_result/unit_exception/unit_rdy            unit completion
//   resp_valid/resp_ready/resp_data/resp_rd/
//   resp_exception                                 tagged result handshake
// -----------------------------------------------------------------------------
interface multdiv_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic        busy;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] unit_result;
    logic        unit_exception;
    logic        unit_rdy;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_exception;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd, flush,
        input  unit_result, unit_exception, unit_rdy, resp_ready,
        output req_ready, busy, unit_a, unit_b, ctrl_MULT, ctrl_DIV,
        output resp_valid, resp_data, resp_rd, resp_exception
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd, flush,
        output unit_result, unit_exception, unit_rdy, resp_ready,
        input  req_ready, busy, unit_a, unit_b, ctrl_MULT, ctrl_DIV,
        input  resp_valid, resp_data, resp_rd, resp_exception
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
//
// Sequencing controller between the execute stage and the shared multi-cycle
// multiply/divide unit. Accepts one request at a time, latches operands and
// destination tag, fires a one-cycle ctrl_MULT / ctrl_DIV pulse, waits for the
// unit's ready (bounded by a watchdog) and presents a tagged result with
// valid/ready backpressure. Divide-by-zero is answered directly without
// starting the unit; flush aborts any in-flight operation.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - multdiv_ctrl_if.slave, all request/unit/response signals
//
// Parameters:
//   MAX_CYCLES - WAIT cycles allowed before the operation is declared hung
//   CNT_W      - watchdog counter width, 2**CNT_W must exceed MAX_CYCLES
// -----------------------------------------------------------------------------
module multdiv_ctrl #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           state_q;
    logic [31:0]      unit_a_q;
    logic [31:0]      unit_b_q;
    logic [4:0]       rd_q;
    logic [31:0]      resp_data_q;
    logic             resp_exc_q;
    logic             ctrl_mult_q;
    logic             ctrl_div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    // Flush blocks acceptance so an aborted cycle can never start new work.
    assign bus.req_ready = (state_q == IDLE) && !bus.flush;
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.busy           = (state_q != IDLE);
    assign bus.resp_valid     = (state_q == DONE);
    assign bus.unit_a         = unit_a_q;
    assign bus.unit_b         = unit_b_q;
    assign bus.ctrl_MULT      = ctrl_mult_q;
    assign bus.ctrl_DIV       = ctrl_div_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.resp_rd        = rd_q;
    assign bus.resp_exception = resp_exc_q;

    // NOTE: every register here is state, so all updates use non-blocking
    // assignments; a blocking '=' would let later statements in this block
    // see the new value within the same edge and break the FSM timing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: these are a handful of flops, not a memory array, so the
            // datapath registers are cleared too and the outputs read 0 in reset.
            state_q     <= IDLE;
            unit_a_q    <= '0;
            unit_b_q    <= '0;
            rd_q        <= '0;
            resp_data_q <= '0;
            resp_exc_q  <= 1'b0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // Start pulses are high only for the single cycle spent in START.
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;

            if (bus.flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            unit_a_q <= bus.req_a;
                            unit_b_q <= bus.req_b;
                            rd_q     <= bus.req_rd;
                            if (bus.req_op && (bus.req_b == '0)) begin
                                // Divide-by-zero answered without touching the unit.
                                resp_data_q <= '0;
                                resp_exc_q  <= 1'b1;
                                state_q     <= DONE;
                            end else begin
                                // The pulse pair carries the latched opcode.
                                ctrl_mult_q <= !bus.req_op;
                                ctrl_div_q  <= bus.req_op;
                                state_q     <= START;
                            end
                        end
                    end

                    START: begin
                        // unit_rdy is not looked at here: it may still be
                        // asserted from the previous operation.
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end

                    WAIT: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (bus.unit_rdy) begin
                            // Ready wins over a watchdog expiry in the same cycle.
                            resp_data_q <= bus.unit_result;
                            resp_exc_q  <= bus.unit_exception;
                            state_q     <= DONE;
                        end else if (cnt_q == CNT_LAST) begin
                            resp_data_q <= '0;
                            resp_exc_q  <= 1'b1;
                            state_q     <= DONE;
                        end
                    end

                    DONE: begin
                        // Returning to IDLE makes req_ready rise only on the
                        // cycle after the response handshake.
                        if (bus.resp_ready) begin
                            state_q <= IDLE;
                        end
                    end

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_ctrl
//
// Self-checking bench for multdiv_ctrl. A behavioural multiply/divide unit
// answers start pulses after a programmable latency (or never, to provoke the
// watchdog). Expected responses are pushed to a scoreboard queue when a
// request is driven and popped when the controller presents a response.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multdiv_ctrl;

    localparam int MAX_CYCLES = 40;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        exc;
    } resp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    multdiv_ctrl_if bus();

    multdiv_ctrl #(
        .MAX_CYCLES(MAX_CYCLES),
        .CNT_W     (6)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    resp_t sb[$];
    int    total = 0;
    int    bad   = 0;

    // ---------------- behavioural multiply/divide unit ----------------
    // unit_rdy rises unit_lat cycles after the cycle holding the start pulse.
    int          unit_lat  = 3;
    bit          unit_hang = 1'b0;
    logic        stale_rdy = 1'b0;
    int          cd;
    logic        model_rdy;
    logic [31:0] model_res;

    assign bus.unit_rdy       = model_rdy | stale_rdy;
    assign bus.unit_result    = model_res;
    assign bus.unit_exception = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cd        <= 0;
            model_rdy <= 1'b0;
            model_res <= '0;
        end else begin
            model_rdy <= 1'b0;
            if (bus.ctrl_MULT || bus.ctrl_DIV) begin
                model_res <= bus.ctrl_MULT ? (bus.unit_a * bus.unit_b) : (bus.unit_a / bus.unit_b);
                if (unit_hang)          cd <= 0;
                else if (unit_lat <= 1) model_rdy <= 1'b1;
                else                    cd <= unit_lat - 1;
            end else if (cd == 1) begin
                model_rdy <= 1'b1;
                cd        <= 0;
            end else if (cd > 1) begin
                cd <= cd - 1;
            end
        end
    end

    // Start pulse counters (tests compare deltas across a transaction).
    int mult_pulses = 0;
    int div_pulses  = 0;
    int both_pulses = 0;
    always @(posedge clock) begin
        if (bus.ctrl_MULT) mult_pulses <= mult_pulses + 1;
        if (bus.ctrl_DIV)  div_pulses  <= div_pulses + 1;
        if (bus.ctrl_MULT && bus.ctrl_DIV) both_pulses <= both_pulses + 1;
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    // Drives one request; returns at the falling edge after the accept edge.
    task automatic send_req(input logic op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!bus.req_ready && n < 100) begin
            tick();
            n++;
        end
        if (bus.req_ready) begin
            bus.req_valid = 1'b1;
            bus.req_op    = op;
            bus.req_a     = a;
            bus.req_b     = b;
            bus.req_rd    = rd;
            tick();
            bus.req_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic wait_resp(input int budget, output bit got, output int cyc);
        cyc = 0;
        while (!bus.resp_valid && cyc < budget) begin
            tick();
            cyc++;
        end
        got = bus.resp_valid;
    endtask

    task automatic pop_exp(output resp_t e, output bit ok);
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            ok = 1'b1;
        end else begin
            e  = '0;
            ok = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick();
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.ctrl_MULT !== 1'b0 ||
            bus.ctrl_DIV !== 1'b0 || bus.unit_a !== 32'd0 || bus.unit_b !== 32'd0 ||
            bus.resp_data !== 32'd0 || bus.resp_rd !== 5'd0 || bus.resp_exception !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b rv=%b m=%b d=%b a=%h b=%h data=%h rd=%0d exc=%b, want all 0",
                     bus.busy, bus.resp_valid, bus.ctrl_MULT, bus.ctrl_DIV, bus.unit_a, bus.unit_b,
                     bus.resp_data, bus.resp_rd, bus.resp_exception);
        end
        reset = 1'b1;
        tick();
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_mult();
        bit ok, got, pok, stable;
        int cyc, m0, d0;
        resp_t e;
        unit_lat = 3;
        m0 = mult_pulses;
        d0 = div_pulses;
        send_req(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, ok);
        sb.push_back('{data: 32'hFFFF_FFEB, rd: 5'd5, exc: 1'b0});
        stable = 1'b1;
        cyc = 0;
        while (!bus.resp_valid && cyc < 100) begin
            if (bus.unit_a !== 32'd7 || bus.unit_b !== 32'hFFFF_FFFD) stable = 1'b0;
            tick();
            cyc++;
        end
        got = bus.resp_valid;
        total++;
        if (!ok || !got || (cyc + 1) != unit_lat + 2) begin
            bad++;
            $display("FAIL mult_latency: accepted=%b valid=%b latency=%0d want %0d", ok, got, cyc + 1, unit_lat + 2);
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL mult_operands_stable: unit_a=%h unit_b=%h want 00000007 fffffffd", bus.unit_a, bus.unit_b);
        end
        pop_exp(e, pok);
        total++;
        if (!pok || bus.resp_data !== e.data || bus.resp_rd !== e.rd || bus.resp_exception !== e.exc) begin
            bad++;
            $display("FAIL mult_result: got data=%h rd=%0d exc=%b want data=%h rd=%0d exc=%b",
                     bus.resp_data, bus.resp_rd, bus.resp_exception, e.data, e.rd, e.exc);
        end
        total++;
        if (mult_pulses - m0 != 1 || div_pulses - d0 != 0) begin
            bad++;
            $display("FAIL mult_pulses: mult=%0d div=%0d want 1 0", mult_pulses - m0, div_pulses - d0);
        end
        tick();
    endtask

    task automatic test_div();
        bit ok, pok, busy_ok;
        int cyc, m0, d0;
        resp_t e;
        unit_lat = 6;
        m0 = mult_pulses;
        d0 = div_pulses;
        send_req(1'b1, 32'd100, 32'd7, 5'd12, ok);
        sb.push_back('{data: 32'd14, rd: 5'd12, exc: 1'b0});
        busy_ok = 1'b1;
        cyc = 0;
        while (!bus.resp_valid && cyc < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        total++;
        if (!ok || !busy_ok || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL div_busy: accepted=%b busy held=%b busy now=%b want 1 1 1", ok, busy_ok, bus.busy);
        end
        pop_exp(e, pok);
        total++;
        if (!pok || bus.resp_valid !== 1'b1 || bus.resp_data !== e.data || bus.resp_rd !== e.rd ||
            bus.resp_exception !== e.exc) begin
            bad++;
            $display("FAIL div_result: valid=%b data=%h rd=%0d exc=%b want valid=1 data=%h rd=%0d exc=%b",
                     bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_exception, e.data, e.rd, e.exc);
        end
        total++;
        if (div_pulses - d0 != 1 || mult_pulses - m0 != 0) begin
            bad++;
            $display("FAIL div_pulses: div=%0d mult=%0d want 1 0", div_pulses - d0, mult_pulses - m0);
        end
        tick();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL div_busy_release: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_div_zero();
        bit ok, got, pok;
        int cyc, d0;
        resp_t e;
        d0 = div_pulses;
        send_req(1'b1, 32'd55, 32'd0, 5'd20, ok);
        sb.push_back('{data: 32'd0, rd: 5'd20, exc: 1'b1});
        wait_resp(100, got, cyc);
        total++;
        if (!ok || !got || cyc != 0) begin
            bad++;
            $display("FAIL dz_latency: valid=%b latency=%0d want 1", got, cyc + 1);
        end
        pop_exp(e, pok);
        total++;
        if (!pok || bus.resp_data !== e.data || bus.resp_rd !== e.rd || bus.resp_exception !== e.exc) begin
            bad++;
            $display("FAIL dz_result: data=%h rd=%0d exc=%b want data=%h rd=%0d exc=%b",
                     bus.resp_data, bus.resp_rd, bus.resp_exception, e.data, e.rd, e.exc);
        end
        tick();
        total++;
        if (div_pulses - d0 != 0) begin
            bad++;
            $display("FAIL dz_no_pulse: div pulses=%0d want 0", div_pulses - d0);
        end
    endtask

    task automatic test_timeout();
        bit ok, got, pok;
        int cyc;
        resp_t e;
        // Unit never answers; a stale ready is shown during START only.
        unit_hang = 1'b1;
        send_req(1'b0, 32'd5, 32'd6, 5'd9, ok);
        sb.push_back('{data: 32'd0, rd: 5'd9, exc: 1'b1});
        stale_rdy = 1'b1;
        tick();
        stale_rdy = 1'b0;
        wait_resp(200, got, cyc);
        total++;
        if (!ok || !got || (cyc + 2) != MAX_CYCLES + 2) begin
            bad++;
            $display("FAIL timeout_latency: valid=%b latency=%0d want %0d", got, cyc + 2, MAX_CYCLES + 2);
        end
        pop_exp(e, pok);
        total++;
        if (!pok || bus.resp_data !== e.data || bus.resp_rd !== e.rd || bus.resp_exception !== e.exc) begin
            bad++;
            $display("FAIL timeout_result: data=%h rd=%0d exc=%b want data=%h rd=%0d exc=%b",
                     bus.resp_data, bus.resp_rd, bus.resp_exception, e.data, e.rd, e.exc);
        end
        tick();
        unit_hang = 1'b0;

        // Ready in the last WAIT cycle beats the watchdog; one later times out.
        for (int k = 0; k < 2; k++) begin
            unit_lat = MAX_CYCLES + k;
            send_req(1'b0, 32'd6, 32'd7, 5'(10 + k), ok);
            sb.push_back('{data: (k == 0) ? 32'd42 : 32'd0, rd: 5'(10 + k), exc: (k != 0)});
            wait_resp(200, got, cyc);
            pop_exp(e, pok);
            total++;
            if (!ok || !got || (cyc + 1) != MAX_CYCLES + 2 || !pok || bus.resp_data !== e.data ||
                bus.resp_rd !== e.rd || bus.resp_exception !== e.exc) begin
                bad++;
                $display("FAIL timeout_edge_%0d: valid=%b latency=%0d data=%h rd=%0d exc=%b want latency=%0d data=%h rd=%0d exc=%b",
                         k, got, cyc + 1, bus.resp_data, bus.resp_rd, bus.resp_exception,
                         MAX_CYCLES + 2, e.data, e.rd, e.exc);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_backpressure();
        bit ok, got, pok, stable;
        int cyc;
        logic [31:0] d0;
        logic [4:0]  r0;
        logic        x0;
        resp_t e;
        unit_lat = 2;
        bus.resp_ready = 1'b0;
        send_req(1'b0, 32'd11, 32'd13, 5'd3, ok);
        sb.push_back('{data: 32'd143, rd: 5'd3, exc: 1'b0});
        wait_resp(100, got, cyc);
        d0 = bus.resp_data;
        r0 = bus.resp_rd;
        x0 = bus.resp_exception;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_data !== d0 ||
                bus.resp_rd !== r0 || bus.resp_exception !== x0) stable = 1'b0;
        end
        total++;
        if (!ok || !got || !stable) begin
            bad++;
            $display("FAIL bp_hold: valid=%b req_ready=%b stable=%b want 1 0 1", bus.resp_valid, bus.req_ready, stable);
        end
        pop_exp(e, pok);
        total++;
        if (!pok || bus.resp_data !== e.data || bus.resp_rd !== e.rd || bus.resp_exception !== e.exc) begin
            bad++;
            $display("FAIL bp_result: data=%h rd=%0d exc=%b want data=%h rd=%0d exc=%b",
                     bus.resp_data, bus.resp_rd, bus.resp_exception, e.data, e.rd, e.exc);
        end
        bus.resp_ready = 1'b1;
        tick();
        total++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: valid=%b req_ready=%b want 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_flush();
        bit ok, leak;
        unit_lat = 10;
        send_req(1'b1, 32'd100, 32'd7, 5'd4, ok);
        tick();
        tick();
        tick();
        // Flush mid-WAIT with a competing request in the same cycle.
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b0;
        bus.req_a     = 32'd2;
        bus.req_b     = 32'd2;
        bus.req_rd    = 5'd8;
        total++;
        if (!ok || bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL flush_req_ready: req_ready=%b busy=%b want 0 1", bus.req_ready, bus.busy);
        end
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle: busy=%b valid=%b want 0 0", bus.busy, bus.resp_valid);
        end
        // The unit's late ready must not resurrect the aborted result.
        leak = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) leak = 1'b1;
        end
        total++;
        if (leak) begin
            bad++;
            $display("FAIL flush_late_rdy: response or busy seen after flush, want none");
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok, got, pok;
        int cyc;
        resp_t e;
        unit_lat = 10;
        send_req(1'b1, 32'd100, 32'd7, 5'd6, ok);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        total++;
        if (!ok || bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.unit_a !== 32'd0 ||
            bus.unit_b !== 32'd0 || bus.resp_data !== 32'd0 || bus.resp_rd !== 5'd0 ||
            bus.ctrl_MULT !== 1'b0 || bus.ctrl_DIV !== 1'b0 || bus.resp_exception !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: busy=%b valid=%b a=%h b=%h data=%h rd=%0d, want all 0",
                     bus.busy, bus.resp_valid, bus.unit_a, bus.unit_b, bus.resp_data, bus.resp_rd);
        end
        tick();
        reset = 1'b1;
        tick();
        unit_lat = 4;
        send_req(1'b1, 32'd9, 32'd3, 5'd7, ok);
        sb.push_back('{data: 32'd3, rd: 5'd7, exc: 1'b0});
        wait_resp(100, got, cyc);
        pop_exp(e, pok);
        total++;
        if (!ok || !got || !pok || bus.resp_data !== e.data || bus.resp_rd !== e.rd || bus.resp_exception !== e.exc) begin
            bad++;
            $display("FAIL post_reset_div: valid=%b data=%h rd=%0d exc=%b want data=%h rd=%0d exc=%b",
                     got, bus.resp_data, bus.resp_rd, bus.resp_exception, e.data, e.rd, e.exc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok, got, pok;
        int cyc;
        resp_t e;
        logic [31:0] a_tab [3] = '{32'd3, 32'd50, 32'hFFFF_FFFF};
        logic [31:0] b_tab [3] = '{32'd4, 32'd5, 32'd2};
        logic        op_tab[3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] x_tab [3] = '{32'd12, 32'd10, 32'h7FFF_FFFF};
        unit_lat = 2;
        for (int i = 0; i < 3; i++) begin
            send_req(op_tab[i], a_tab[i], b_tab[i], 5'(i + 1), ok);
            sb.push_back('{data: x_tab[i], rd: 5'(i + 1), exc: 1'b0});
            wait_resp(100, got, cyc);
            pop_exp(e, pok);
            total++;
            if (!ok || !got || !pok || bus.resp_data !== e.data || bus.resp_rd !== e.rd ||
                bus.resp_exception !== e.exc) begin
                bad++;
                $display("FAIL b2b_%0d: valid=%b data=%h rd=%0d exc=%b want data=%h rd=%0d exc=%b",
                         i, got, bus.resp_data, bus.resp_rd, bus.resp_exception, e.data, e.rd, e.exc);
            end
        end
        tick();
        total++;
        if (both_pulses != 0 || sb.size() != 0) begin
            bad++;
            $display("FAIL pulse_overlap_or_leftover: both=%0d pending=%0d want 0 0", both_pulses, sb.size());
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_rd     = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b1;

        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_timeout();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
